// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
//   Bundle between the VGA timing generator, the color mapper and the DAC pins.
//
//   Raster side : DrawX, DrawY (10 b each), pix_tick, frame_start
//   Color input : pix_R, pix_G, pix_B (8 b each), combinational from the mapper
//   DAC pins    : VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
//                 VGA_R, VGA_G, VGA_B (8 b each)
//
//   master : the timing generator (drives raster + pins, reads color)
//   slave  : the consumer side (color mapper / pin sink)
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       pix_tick;
    logic       frame_start;
    logic [7:0] pix_R;
    logic [7:0] pix_G;
    logic [7:0] pix_B;
    logic       VGA_CLK;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;

    modport master (
        output DrawX, DrawY, pix_tick, frame_start,
        output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
        output VGA_R, VGA_G, VGA_B,
        input  pix_R, pix_G, pix_B
    );

    modport slave (
        input  DrawX, DrawY, pix_tick, frame_start,
        input  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
        input  VGA_R, VGA_G, VGA_B,
        output pix_R, pix_G, pix_B
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   640x480@60 raster timing (default parameters) from a system clock that is
//   CLK_DIV times the pixel rate. Produces DrawX/DrawY for the color mapper,
//   registers the returned color together with HS/VS/BLANK_N so all DAC pins
//   stay phase-aligned, and emits a one-cycle frame_start at entry to
//   vertical blank.
//
//   Clk     : system clock, the only clock
//   Reset_n : asynchronous active-low reset
//   vga     : vga_timing_gen_if.master (raster outputs, color in, DAC pins)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_VIS_C  = 10'(H_VISIBLE);
    localparam logic [9:0]       V_VIS_C  = 10'(V_VISIBLE);
    localparam logic [9:0]       HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0]       HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0]       VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0]       VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0] div_reg, div_next;
    logic [9:0]       h_reg, h_next;
    logic [9:0]       v_reg, v_next;
    logic             vga_clk_reg;
    logic             tick_d_reg;
    logic             frame_start_reg, frame_start_next;
    logic             hs_reg, vs_reg, blank_n_reg;
    logic             pix_tick;
    logic             visible;
    logic             hs_active, vs_active;

    logic [7:0] pix_in  [3];
    logic [7:0] rgb_reg [3];

    assign pix_tick = (div_reg == DIV_LAST);

    always_comb begin
        div_next         = div_reg + 1'b1;
        h_next           = h_reg;
        v_next           = v_reg;
        visible          = (h_reg < H_VIS_C) && (v_reg < V_VIS_C);
        hs_active        = (h_reg >= HS_START) && (h_reg < HS_END);
        vs_active        = (v_reg >= VS_START) && (v_reg < VS_END);
        // Counters have just stepped onto (0, V_VISIBLE) when the previous
        // cycle was a tick; this keeps the strobe to a single Clk cycle.
        frame_start_next = tick_d_reg && (h_reg == 10'd0) && (v_reg == V_VIS_C);

        if (pix_tick) begin
            div_next = '0;
            if (h_reg == H_LAST) begin
                h_next = 10'd0;
                v_next = (v_reg == V_LAST) ? 10'd0 : v_reg + 10'd1;
            end else begin
                h_next = h_reg + 10'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_reg         <= '0;
            h_reg           <= 10'd0;
            v_reg           <= 10'd0;
            vga_clk_reg     <= 1'b0;
            tick_d_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
            hs_reg          <= 1'b1;
            vs_reg          <= 1'b1;
            blank_n_reg     <= 1'b0;
        end else begin
            div_reg         <= div_next;
            h_reg           <= h_next;
            v_reg           <= v_next;
            // Low for the first half of the pixel, high for the second: it
            // falls together with the output registers and rises mid-pixel.
            vga_clk_reg     <= (div_next >= DIV_HALF);
            tick_d_reg      <= pix_tick;
            frame_start_reg <= frame_start_next;
            if (pix_tick) begin
                hs_reg      <= ~hs_active;
                vs_reg      <= ~vs_active;
                blank_n_reg <= visible;
            end
        end
    end

    assign pix_in[0] = vga.pix_R;
    assign pix_in[1] = vga.pix_G;
    assign pix_in[2] = vga.pix_B;

    // Color channels share one capture rule: sampled on the tick from the
    // pre-increment position, forced to zero outside the visible region.
    for (genvar gi = 0; gi < 3; gi++) begin : g_rgb
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                rgb_reg[gi] <= 8'd0;
            end else if (pix_tick) begin
                rgb_reg[gi] <= visible ? pix_in[gi] : 8'd0;
            end
        end
    end

    assign vga.DrawX       = h_reg;
    assign vga.DrawY       = v_reg;
    assign vga.pix_tick    = pix_tick;
    assign vga.frame_start = frame_start_reg;
    assign vga.VGA_CLK     = vga_clk_reg;
    assign vga.VGA_HS      = hs_reg;
    assign vga.VGA_VS      = vs_reg;
    assign vga.VGA_BLANK_N = blank_n_reg;
    assign vga.VGA_SYNC_N  = 1'b0;
    assign vga.VGA_R       = rgb_reg[0];
    assign vga.VGA_G       = rgb_reg[1];
    assign vga.VGA_B       = rgb_reg[2];
endmodule
